mul_tree_result_fifo_bf16: RTL and testbench
============================================

Name: mul_tree_result_fifo_bf16

Overview:
- Downstream stage of the bf16 multiply tree. Each cycle it captures the tree's 4-lane result bus and per-lane strobes.
- It compacts the valid lanes in ascending lane order into a single-word FIFO and presents them as a valid/ready stream of 16-bit bf16 products.
- The tree cannot be stalled, so the block exports a credit signal (space_ok) that upstream uses to gate mul_stb, plus a sticky overflow flag.

Parameters:
- DEPTH, 32, FIFO entries of 16 bits; power of two, >= 8.
- SLACK, 16, minimum free entries required for space_ok; covers in-flight tree results.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  2  tree mode: 0 two_in, 1 three_in, 2 four_in, 3 six_in.
- res_data  input  64  tree outputs; lane i is bits [16*i+15:16*i].
- res_stbs  input  4  per-lane result strobes from the tree.
- flush  input  1  synchronous clear of FIFO contents.
- out_data  output  16  head-of-FIFO bf16 word.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head word.
- space_ok  output  1  free entries >= SLACK; upstream may assert mul_stb only while high.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky; a result beat was dropped.

Behaviour:
- Reset (async, rst=1):
  - rd_ptr=wr_ptr=0, count=0, overflow=0.
  - out_valid=0, space_ok=1, out_data=0.
  - Memory contents are don't-care.
- Lane mask by mode:
  - mode 0: lanes 0-3.
  - mode 1 or 2: lanes 0-1.
  - mode 3: lane 0 only.
- Effective strobe: eff[i] = res_stbs[i] & mask[i]. Lanes outside the mask are ignored even if strobed.
- k = popcount(eff), range 0..4.
- Push:
  - Condition: k > 0 and k <= DEPTH - count, using pre-pop count (conservative).
  - The set lanes are written at wr_ptr, wr_ptr+1, ... in ascending lane index, with no gaps.
  - wr_ptr advances by k modulo DEPTH, so the pointers wrap.
- Drop:
  - Condition: k > DEPTH - count. The whole beat is discarded (no partial write).
  - overflow is set and stays set until rst or flush.
- Pop:
  - Condition: out_valid & out_ready. rd_ptr advances by 1 modulo DEPTH.
  - out_data = mem[rd_ptr] combinationally (first-word fall-through).
  - out_data holds its value while out_valid=1 and out_ready=0.
- Simultaneous push and pop: count_next = count + k_accepted - pop. Both occur in the same cycle.
- A word pushed in cycle N is visible on out_data/out_valid in cycle N+1. No same-cycle bypass.
- Empty FIFO:
  - out_valid=0; out_ready is ignored.
  - out_data is the stale mem[rd_ptr]; consumers must not sample it.
- Full FIFO: any beat with k >= 1 is dropped, even if a pop occurs in that cycle.
- space_ok = (DEPTH - count) >= SLACK, registered from count_next so it is glitch-free.
- flush:
  - Effect: pointers and count go to 0 and overflow is cleared next cycle.
  - flush has priority: a push or pop in the same cycle is discarded.
- A mode change mid-stream is legal. The mask is applied per beat using mode in that cycle.

Decomposition:
- Shared package mul_tree_pkg:
  - mode constants TWO_IN=2'd0, THREE_IN=2'd1, FOUR_IN=2'd2, SIX_IN=2'd3.
  - BF16_ONE=16'h3F80.
  - LANES=4, LANE_W=16.
  - These constants are shared with mul_tree_bf16.
- Sub-module lane_compactor4: purely combinational.
  - Inputs: eff[3:0], res_data.
  - Outputs: k and four compacted words, slot j = j-th set lane.
- The top level holds the memory, pointers, count and flags.

Test Plan:
- Four-lane push:
  - Stimulus: rst pulse, then mode=0, res_stbs=4'hF, res_data={4080,4040,4000,3F80} for 1 cycle, out_ready=0.
  - Response: count=4 next cycle. Then with out_ready=1, pops deliver 3F80, 4000, 4040, 4080 in order, then out_valid=0.
- Compaction and masking:
  - Stimulus 1: mode=0, res_stbs=4'b1010, lanes 1=4000, 3=4080.
  - Response 1: FIFO holds 4000 then 4080, count=2.
  - Stimulus 2: mode=3, res_stbs=4'hF.
  - Response 2: only lane 0 is written, count increments by 1.
- Full and overflow:
  - Stimulus: DEPTH=32, out_ready=0, eight beats of k=4.
  - Response: count=32, space_ok=0.
  - Stimulus: a ninth beat of k=1.
  - Response: the beat is dropped, overflow=1, count stays 32. A subsequent pop does not clear overflow.
- Simultaneous push and pop at wrap:
  - Stimulus: rd_ptr=wr_ptr=30 (set up via pushes and pops), count=0, two-lane beats while out_ready=1 continuously.
  - Response: the pointers wrap past 31 to 0, data order is preserved, and count matches the model on every cycle.
- space_ok threshold:
  - Stimulus: fill to count=16.
  - Response: space_ok=1.
  - Stimulus: push 1 more word.
  - Response: space_ok=0 the following cycle. After one pop it returns to 1.
- Reset and flush mid-operation:
  - Stimulus 1: async rst asserted between clock edges with count=10.
  - Response 1: out_valid, count and overflow go to 0 immediately.
  - Stimulus 2: flush together with a k=4 beat and a pop.
  - Response 2: count=0 and overflow=0 next cycle; nothing is written.

Source files
------------

// File: rtl/mul_tree_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_tree_pkg
//  Description : Constants and helpers shared by the bf16 multiply tree and
//                its result FIFO (mode codes, lane geometry, lane masks).
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_tree_pkg;

    localparam logic [1:0] TWO_IN   = 2'd0;
    localparam logic [1:0] THREE_IN = 2'd1;
    localparam logic [1:0] FOUR_IN  = 2'd2;
    localparam logic [1:0] SIX_IN   = 2'd3;

    localparam logic [15:0] BF16_ONE = 16'h3F80;

    localparam int LANES  = 4;
    localparam int LANE_W = 16;
    localparam int K_W    = 3;

    // Lanes the tree actually drives in each mode; the rest carry junk.
    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] mode);
        case (mode)
            TWO_IN:             return 4'b1111;
            THREE_IN, FOUR_IN:  return 4'b0011;
            default:            return 4'b0001;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_compactor4.sv
`default_nettype none
// ============================================================================
//  Module      : lane_compactor4
//  Description : Packs the strobed lanes of a 4-lane result bus into
//                consecutive slots in ascending lane order; reports the count.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_compactor4
    import mul_tree_pkg::*;
(
    input  logic [LANES-1:0]              i_eff,
    input  logic [LANES*LANE_W-1:0]       i_res_data,
    output logic [K_W-1:0]                o_k,
    output logic [LANES-1:0][LANE_W-1:0]  o_slots
);

    logic [K_W-1:0] w_idx;

    always_comb begin
        o_slots = '0;
        w_idx   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i_eff[i]) begin
                o_slots[w_idx[1:0]] = i_res_data[i*LANE_W +: LANE_W];
                w_idx               = w_idx + 3'd1;
            end
        end
        o_k = w_idx;
    end

endmodule
`default_nettype wire

// File: rtl/mul_tree_result_fifo_bf16.sv
`default_nettype none
// ============================================================================
//  Module      : mul_tree_result_fifo_bf16
//  Description : Compacting result FIFO behind the bf16 multiply tree with a
//                credit output (space_ok) and a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_tree_result_fifo_bf16
    import mul_tree_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int SLACK = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                i_mode,
    input  logic [LANES*LANE_W-1:0]   i_res_data,
    input  logic [LANES-1:0]          i_res_stbs,
    input  logic                      i_flush,
    output logic [LANE_W-1:0]         o_out_data,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic                      o_space_ok,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_overflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_SLACK = c_CW'(SLACK);

    typedef logic [c_AW-1:0] ptr_t;

    logic [LANE_W-1:0]              r_mem [DEPTH];
    ptr_t                           r_wr_ptr;
    ptr_t                           r_rd_ptr;
    logic [c_CW-1:0]                r_count;
    logic                           r_overflow;
    logic                           r_space_ok;

    logic [LANES-1:0]               w_eff;
    logic [K_W-1:0]                 w_k;
    logic [LANES-1:0][LANE_W-1:0]   w_slots;
    logic [c_CW-1:0]                w_k_ext;
    logic [c_CW-1:0]                w_free;
    logic                           w_push;
    logic                           w_drop;
    logic                           w_valid;
    logic                           w_pop;
    logic [c_CW-1:0]                w_count_next;

    assign w_eff = i_res_stbs & lane_mask(i_mode);

    lane_compactor4 u_compactor (
        .i_eff      (w_eff),
        .i_res_data (i_res_data),
        .o_k        (w_k),
        .o_slots    (w_slots)
    );

    // Acceptance uses pre-pop occupancy so a full FIFO drops even when popping.
    assign w_k_ext = {{(c_CW-K_W){1'b0}}, w_k};
    assign w_free  = c_DEPTH - r_count;
    assign w_push  = (w_k != '0) && (w_k_ext <= w_free);
    assign w_drop  = (w_k_ext > w_free);
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && i_out_ready;

    always_comb begin
        w_count_next = r_count;
        if (i_flush) begin
            w_count_next = '0;
        end else begin
            if (w_push) w_count_next = w_count_next + w_k_ext;
            if (w_pop)  w_count_next = w_count_next - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_space_ok <= 1'b1;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_count    <= w_count_next;
            r_space_ok <= ((c_DEPTH - w_count_next) >= c_SLACK);
            if (i_flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push) begin
                    for (int j = 0; j < LANES; j++) begin
                        if (K_W'(j) < w_k) r_mem[r_wr_ptr + ptr_t'(j)] <= w_slots[j];
                    end
                    r_wr_ptr <= r_wr_ptr + ptr_t'(w_k);
                end
                if (w_pop)  r_rd_ptr   <= r_rd_ptr + 1'b1;
                if (w_drop) r_overflow <= 1'b1;
            end
        end
    end

    assign o_out_data  = r_mem[r_rd_ptr];
    assign o_out_valid = w_valid;
    assign o_space_ok  = r_space_ok;
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mul_tree_result_fifo_bf16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_tree_result_fifo_bf16
//  Description : Self-checking bench for the compacting bf16 result FIFO,
//                compared against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_tree_result_fifo_bf16;

    localparam int DEPTH = 32;
    localparam int SLACK = 16;

    logic        clk;
    logic        rst;
    logic [1:0]  i_mode;
    logic [63:0] i_res_data;
    logic [3:0]  i_res_stbs;
    logic        i_flush;
    logic [15:0] o_out_data;
    logic        o_out_valid;
    logic        i_out_ready;
    logic        o_space_ok;
    logic [5:0]  o_count;
    logic        o_overflow;

    mul_tree_result_fifo_bf16 #(.DEPTH(DEPTH), .SLACK(SLACK)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_mode      (i_mode),
        .i_res_data  (i_res_data),
        .i_res_stbs  (i_res_stbs),
        .i_flush     (i_flush),
        .o_out_data  (o_out_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_space_ok  (o_space_ok),
        .o_count     (o_count),
        .o_overflow  (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] q[$];
    bit          m_ovf;
    int          n_checks;
    int          n_fails;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("count", 32'(o_count), 32'(q.size()));
        check("out_valid", 32'(o_out_valid), 32'(q.size() != 0));
        if (q.size() != 0) check("out_data", 32'(o_out_data), 32'(q[0]));
        check("overflow", 32'(o_overflow), 32'(m_ovf));
        check("space_ok", 32'(o_space_ok), 32'((DEPTH - q.size()) >= SLACK));
    endtask

    // One clock of stimulus; model advances at the edge, outputs checked 1ns later.
    task automatic cycle(input logic [1:0] m, input logic [3:0] s, input logic [63:0] d,
                         input logic f, input logic r);
        int          nl;
        int          free;
        logic [15:0] beat[$];
        i_mode      = m;
        i_res_stbs  = s;
        i_res_data  = d;
        i_flush     = f;
        i_out_ready = r;
        @(posedge clk);
        if (f) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            nl = (m == 2'd0) ? 4 : (m == 2'd3) ? 1 : 2;
            for (int i = 0; i < nl; i++) if (s[i]) beat.push_back(d[16*i +: 16]);
            free = DEPTH - q.size();
            if (r && q.size() != 0) void'(q.pop_front());
            if (beat.size() > free) m_ovf = 1'b1;
            else foreach (beat[i]) q.push_back(beat[i]);
        end
        #1;
        compare_all();
    endtask

    task automatic idle(input logic r);
        cycle(2'd0, 4'h0, 64'h0, 1'b0, r);
    endtask

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        m_ovf       = 1'b0;
        rst         = 1'b1;
        i_mode      = 2'd0;
        i_res_data  = '0;
        i_res_stbs  = '0;
        i_flush     = 1'b0;
        i_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        compare_all();
        check("reset_out_data", 32'(o_out_data), 32'h0);

        // Four-lane push then drain in lane order
        cycle(2'd0, 4'hF, 64'h4080_4040_4000_3F80, 1'b0, 1'b0);
        check("four_lane_count", 32'(o_count), 32'd4);
        check("four_lane_head", 32'(o_out_data), 32'h3F80);
        repeat (5) idle(1'b1);

        // Compaction and masking
        cycle(2'd0, 4'b1010, 64'h4080_1111_4000_2222, 1'b0, 1'b0);
        check("compact_head", 32'(o_out_data), 32'h4000);
        cycle(2'd3, 4'hF, 64'hAAAA_BBBB_CCCC_3F80, 1'b0, 1'b0);
        check("mask_count", 32'(o_count), 32'd3);
        repeat (4) idle(1'b1);

        // Fill to full, overflow, pop keeps overflow, flush with push and pop
        repeat (8) cycle(2'd0, 4'hF, {$urandom, $urandom}, 1'b0, 1'b0);
        check("full_count", 32'(o_count), 32'd32);
        cycle(2'd3, 4'h1, 64'h1234, 1'b0, 1'b0);
        check("overflow_set", 32'(o_overflow), 32'd1);
        cycle(2'd3, 4'h1, 64'h5678, 1'b0, 1'b1);
        idle(1'b1);
        cycle(2'd0, 4'hF, {$urandom, $urandom}, 1'b1, 1'b1);
        check("flush_count", 32'(o_count), 32'd0);

        // Park pointers at 30, then stream two-lane beats across the wrap
        repeat (7) cycle(2'd0, 4'hF, {$urandom, $urandom}, 1'b0, 1'b0);
        cycle(2'd1, 4'h3, {$urandom, $urandom}, 1'b0, 1'b0);
        repeat (30) idle(1'b1);
        repeat (10) cycle(2'd1, 4'h3, {$urandom, $urandom}, 1'b0, 1'b1);
        repeat (12) idle(1'b1);

        // space_ok threshold
        cycle(2'd0, 4'h0, 64'h0, 1'b1, 1'b0);
        repeat (4) cycle(2'd0, 4'hF, {$urandom, $urandom}, 1'b0, 1'b0);
        check("space_at_16", 32'(o_space_ok), 32'd1);
        cycle(2'd3, 4'h1, {$urandom, $urandom}, 1'b0, 1'b0);
        check("space_at_17", 32'(o_space_ok), 32'd0);
        idle(1'b1);

        // Async reset with ten words buffered
        cycle(2'd0, 4'h0, 64'h0, 1'b1, 1'b0);
        repeat (2) cycle(2'd0, 4'hF, {$urandom, $urandom}, 1'b0, 1'b0);
        cycle(2'd2, 4'hF, {$urandom, $urandom}, 1'b0, 1'b0);
        check("pre_reset_count", 32'(o_count), 32'd10);
        #2 rst = 1'b1;
        #1;
        q.delete();
        m_ovf = 1'b0;
        compare_all();
        check("async_rst_out_data", 32'(o_out_data), 32'h0);
        #2 rst = 1'b0;
        idle(1'b0);

        // Randomized traffic with mode changes, back-pressure and rare flushes
        for (int n = 0; n < 2000; n++) begin
            cycle(2'($urandom), 4'($urandom), {$urandom, $urandom},
                  ($urandom_range(0, 63) == 0), ($urandom_range(0, 99) < 45));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
